// File: rtl/ricosoc_iomem_arbiter.sv
// Two-master valid/ready arbiter sharing the ricosoc iomem slave bus, with one transaction in flight.
// Define RICOSOC_ARB_TIMEOUT_EN to enable the bus-timeout watchdog that forces completion with 32'hFFFF_FFFF.
module ricosoc_iomem_arbiter #(
    parameter int unsigned FIXED_PRIO     = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    input  logic        s_ready,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,

    output logic [1:0]  grant,
    output logic        timeout_irq
);

    localparam int unsigned CNT_W = 16;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..65535");
    end

    // State encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BUSY_M0 = 2'b01,
        BUSY_M1 = 2'b10
    } state_t;

    state_t r_state;
    logic   r_last_m1;

    logic w_sel_m0;
    logic w_sel_m1;
    logic w_req;
    logic w_timeout;
    logic w_done;
    logic w_pick_m0;

    assign w_sel_m0  = (r_state == BUSY_M0);
    assign w_sel_m1  = (r_state == BUSY_M1);
    assign w_req     = (w_sel_m0 & m0_valid) | (w_sel_m1 & m1_valid);
    assign w_done    = w_req & (s_ready | w_timeout);
    assign w_pick_m0 = m0_valid & (~m1_valid | (FIXED_PRIO != 0) | r_last_m1);

`ifdef RICOSOC_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_cnt;

    // A ready slave always beats the watchdog in the same cycle.
    assign w_timeout = w_req & ~s_ready & (r_cnt == TO_LIMIT);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_last_m1 <= 1'b1;
`ifdef RICOSOC_ARB_TIMEOUT_EN
            r_cnt     <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_m0) begin
                        r_state <= BUSY_M0;
                    end else if (m1_valid) begin
                        r_state <= BUSY_M1;
                    end
                end
                BUSY_M0, BUSY_M1: begin
                    // A master dropping valid mid-transaction abandons it without touching fairness.
                    if (!w_req) begin
                        r_state <= IDLE;
                    end else if (w_done) begin
                        r_state   <= IDLE;
                        r_last_m1 <= w_sel_m1;
                    end
                end
                default: r_state <= IDLE;
            endcase
`ifdef RICOSOC_ARB_TIMEOUT_EN
            if (r_state == IDLE) begin
                r_cnt <= '0;
            end else if (!s_ready && r_cnt != {CNT_W{1'b1}}) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
`endif
        end
    end

    assign grant       = r_state;
    assign timeout_irq = w_timeout;

    assign s_valid = w_req & ~w_timeout;
    assign s_wstrb = w_sel_m0 ? m0_wstrb : (w_sel_m1 ? m1_wstrb : 4'b0000);
    assign s_addr  = w_sel_m0 ? m0_addr  : (w_sel_m1 ? m1_addr  : 32'h0000_0000);
    assign s_wdata = w_sel_m0 ? m0_wdata : (w_sel_m1 ? m1_wdata : 32'h0000_0000);

    assign m0_ready = w_sel_m0 & (s_ready | w_timeout);
    assign m1_ready = w_sel_m1 & (s_ready | w_timeout);

    // The losing master sees a quiet bus; a forced completion returns all-ones.
    assign m0_rdata = !w_sel_m0 ? 32'h0000_0000 : (w_timeout ? 32'hFFFF_FFFF : s_rdata);
    assign m1_rdata = !w_sel_m1 ? 32'h0000_0000 : (w_timeout ? 32'hFFFF_FFFF : s_rdata);

endmodule

// File: tb/tb_ricosoc_iomem_arbiter.sv
// Directed scoreboard bench for ricosoc_iomem_arbiter: a round-robin instance under test plus a
// fixed-priority twin fed the same masters behind a zero-wait slave.
module tb_ricosoc_iomem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        m0_valid, m1_valid, s_ready;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;

    logic        m0_ready, m1_ready, s_valid, timeout_irq;
    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  grant;

    logic        fp_m0_ready, fp_m1_ready, fp_s_valid, fp_s_ready, fp_timeout_irq;
    logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;
    logic [3:0]  fp_s_wstrb;
    logic [1:0]  fp_grant;

    assign fp_s_ready = fp_s_valid;

    ricosoc_iomem_arbiter #(.FIXED_PRIO(0), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_wstrb(m0_wstrb),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_wstrb(m1_wstrb),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
        .grant(grant), .timeout_irq(timeout_irq)
    );

    ricosoc_iomem_arbiter #(.FIXED_PRIO(1)) dut_fp (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_ready(fp_m0_ready), .m0_wstrb(m0_wstrb),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(fp_m0_rdata),
        .m1_valid(m1_valid), .m1_ready(fp_m1_ready), .m1_wstrb(m1_wstrb),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(fp_m1_rdata),
        .s_valid(fp_s_valid), .s_ready(fp_s_ready), .s_wstrb(fp_s_wstrb),
        .s_addr(fp_s_addr), .s_wdata(fp_s_wdata), .s_rdata(s_rdata),
        .grant(fp_grant), .timeout_irq(fp_timeout_irq)
    );

    typedef struct packed {
        logic [1:0]  own;
        logic [31:0] rdata;
        logic        irq;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   fp_m0_cnt = 0;
    int   fp_m1_cnt = 0;
    logic model_last_m1;
    logic [1:0] exp_own;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Completion monitor: every master ready must match the oldest expected completion.
    task automatic mon();
        exp_t e;
        if (fp_m0_ready) fp_m0_cnt++;
        if (fp_m1_ready) fp_m1_cnt++;
        if (m0_ready || m1_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", 32'({m1_ready, m0_ready}), 32'h0);
            end else begin
                e = sb.pop_front();
                chk("sb_owner", 32'({m1_ready, m0_ready}), 32'(e.own));
                chk("sb_grant", 32'(grant), 32'(e.own));
                chk("sb_rdata", (e.own == 2'b01) ? m0_rdata : m1_rdata, e.rdata);
                chk("sb_other_rdata", (e.own == 2'b01) ? m1_rdata : m0_rdata, 32'h0);
                chk("sb_irq", 32'(timeout_irq), 32'(e.irq));
            end
        end
    endtask

    task automatic half();
        @(negedge clk);
        mon();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        m0_valid = 1'b0; m0_wstrb = 4'h0; m0_addr = 32'h0; m0_wdata = 32'h0;
        m1_valid = 1'b0; m1_wstrb = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
        s_ready = 1'b0; s_rdata = 32'hA5A5_A5A5;

        repeat (2) begin half(); adv(); end
        half();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_s_valid", 32'(s_valid), 32'h0);
        chk("rst_s_wstrb", 32'(s_wstrb), 32'h0);
        chk("rst_s_addr", s_addr, 32'h0);
        chk("rst_s_wdata", s_wdata, 32'h0);
        chk("rst_ready", 32'({m1_ready, m0_ready}), 32'h0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        chk("rst_m1_rdata", m1_rdata, 32'h0);
        chk("rst_irq", 32'(timeout_irq), 32'h0);
        adv(); resetn = 1'b1; s_rdata = 32'h0;
        half(); adv();

        // Single m0 read with one wait cycle
        m0_valid = 1'b1; m0_addr = 32'h0200_0010; m0_wstrb = 4'h0;
        half();
        chk("rd_lat_grant", 32'(grant), 32'h0);
        chk("rd_lat_svalid", 32'(s_valid), 32'h0);
        adv(); half();
        chk("rd_grant", 32'(grant), 32'h1);
        chk("rd_svalid", 32'(s_valid), 32'h1);
        chk("rd_saddr", s_addr, 32'h0200_0010);
        chk("rd_wait_ready", 32'({m1_ready, m0_ready}), 32'h0);
        adv(); s_ready = 1'b1; s_rdata = 32'hCAFE_F00D;
        sb.push_back('{own: 2'b01, rdata: 32'hCAFE_F00D, irq: 1'b0});
        half();
        adv(); m0_valid = 1'b0; s_ready = 1'b0; s_rdata = 32'h0;
        half();
        chk("rd_done_grant", 32'(grant), 32'h0);
        chk("rd_sb_drain", 32'(sb.size()), 32'h0);
        model_last_m1 = 1'b0;

        // m1 write
        adv(); m1_valid = 1'b1; m1_wstrb = 4'b0011; m1_addr = 32'h0300_0004; m1_wdata = 32'h1234_5678;
        half();
        adv(); s_rdata = 32'hDEAD_BEEF;
        half();
        chk("wr_grant", 32'(grant), 32'h2);
        chk("wr_svalid", 32'(s_valid), 32'h1);
        chk("wr_wstrb", 32'(s_wstrb), 32'h3);
        chk("wr_addr", s_addr, 32'h0300_0004);
        chk("wr_wdata", s_wdata, 32'h1234_5678);
        chk("wr_wait_ready", 32'(m1_ready), 32'h0);
        chk("wr_m0_rdata", m0_rdata, 32'h0);
        adv(); s_ready = 1'b1;
        sb.push_back('{own: 2'b10, rdata: 32'hDEAD_BEEF, irq: 1'b0});
        half();
        adv(); m1_valid = 1'b0; m1_wstrb = 4'h0; s_ready = 1'b0; s_rdata = 32'h0;
        half();
        chk("wr_done_grant", 32'(grant), 32'h0);
        model_last_m1 = 1'b1;
        adv(); half();

        // Continuous contention, zero-wait slave
        adv(); fp_m0_cnt = 0; fp_m1_cnt = 0;
        m0_valid = 1'b1; m1_valid = 1'b1; m0_addr = 32'h0200_0020; m1_addr = 32'h0300_0020;
        for (int k = 0; k < 4; k++) begin
            half();
            chk("rr_idle_grant", 32'(grant), 32'h0);
            adv();
            exp_own = model_last_m1 ? 2'b01 : 2'b10;
            s_ready = 1'b1; s_rdata = 32'h1000_0000 + 32'(k);
            sb.push_back('{own: exp_own, rdata: 32'h1000_0000 + 32'(k), irq: 1'b0});
            half();
            model_last_m1 = (exp_own == 2'b10);
            adv(); s_ready = 1'b0; s_rdata = 32'h0;
        end
        m0_valid = 1'b0; m1_valid = 1'b0;
        half();
        chk("fp_m0_served", 32'(fp_m0_cnt), 32'd4);
        chk("fp_m1_served", 32'(fp_m1_cnt), 32'd0);
        chk("rr_sb_drain", 32'(sb.size()), 32'h0);

        // Asynchronous reset during a stalled m1 transaction
        adv(); m1_valid = 1'b1; m1_addr = 32'h0300_0040;
        half();
        adv(); half();
        chk("rst_pre_grant", 32'(grant), 32'h2);
        chk("rst_pre_svalid", 32'(s_valid), 32'h1);
        adv(); half();
        #2 resetn = 1'b0;
        #1;
        chk("rst_async_grant", 32'(grant), 32'h0);
        chk("rst_async_svalid", 32'(s_valid), 32'h0);
        chk("rst_async_m1_ready", 32'(m1_ready), 32'h0);
        adv(); m0_valid = 1'b1; m0_addr = 32'h0200_0050;
        half();
        adv(); resetn = 1'b1;
        half();
        chk("rst_rel_grant", 32'(grant), 32'h0);
        adv(); half();
        chk("rst_m0_first", 32'(grant), 32'h1);
        adv(); s_ready = 1'b1; s_rdata = 32'h0BAD_F00D;
        sb.push_back('{own: 2'b01, rdata: 32'h0BAD_F00D, irq: 1'b0});
        half();
        adv(); m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0; s_rdata = 32'h0;
        half();
        chk("rst_done_grant", 32'(grant), 32'h0);

`ifdef RICOSOC_ARB_TIMEOUT_EN
        // Watchdog: slave never ready, forced completion on the 9th busy cycle
        adv(); m0_valid = 1'b1; m0_addr = 32'h0200_0070;
        half();
        adv(); half();
        chk("to_grant", 32'(grant), 32'h1);
        chk("to_irq_early", 32'(timeout_irq), 32'h0);
        repeat (7) begin adv(); half(); end
        chk("to_hold_grant", 32'(grant), 32'h1);
        chk("to_hold_svalid", 32'(s_valid), 32'h1);
        adv();
        sb.push_back('{own: 2'b01, rdata: 32'hFFFF_FFFF, irq: 1'b1});
        half();
        chk("to_svalid_forced", 32'(s_valid), 32'h0);
        adv(); s_ready = 1'b1; s_rdata = 32'h1111_1111; m0_valid = 1'b0;
        half();
        chk("to_late_grant", 32'(grant), 32'h0);
        chk("to_late_ready", 32'(m0_ready), 32'h0);
        chk("to_late_irq", 32'(timeout_irq), 32'h0);
        adv(); s_ready = 1'b0; s_rdata = 32'h0;
        half();
`else
        // Long stall without a watchdog ends in one normal completion
        adv(); m0_valid = 1'b1; m0_addr = 32'h0200_0060;
        half();
        adv(); half();
        chk("stall_grant", 32'(grant), 32'h1);
        repeat (1000) begin adv(); half(); end
        chk("stall_hold_grant", 32'(grant), 32'h1);
        chk("stall_irq", 32'(timeout_irq), 32'h0);
        adv(); s_ready = 1'b1; s_rdata = 32'h5A5A_5A5A;
        sb.push_back('{own: 2'b01, rdata: 32'h5A5A_5A5A, irq: 1'b0});
        half();
        adv(); m0_valid = 1'b0; s_ready = 1'b0; s_rdata = 32'h0;
        half();
        chk("stall_done_grant", 32'(grant), 32'h0);
`endif

        chk("sb_drain", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
